// File: rtl/moving_average_n.sv
// Run-time selectable boxcar average over N = 2^log2_len samples (running sum + ring buffer).
// Define MOVING_AVERAGE_N_ROUND_EN to round half toward +inf instead of flooring.
//
// state  | meaning
// -------+-----------------------------------------------
// S_FILL | fewer than N samples accepted since restart
// S_RUN  | window full, fill_cnt saturated at N
module moving_average_n #(
   parameter int DATA_WIDTH   = 16,
   parameter int LOG2_MAX_LEN = 5,
   parameter int LEN_W        = 3
) (
   input  logic                         clk,
   input  logic                         aresetn,
   input  logic                         ce,
   input  logic                         clr,
   input  logic [LEN_W-1:0]             log2_len,
   input  logic signed [DATA_WIDTH-1:0] din,
   output logic signed [DATA_WIDTH-1:0] dout,
   output logic                         dout_valid,
   output logic                         filled
);

   localparam int DEPTH = 1 << LOG2_MAX_LEN;
   localparam int SUM_W = DATA_WIDTH + LOG2_MAX_LEN;
   localparam int CNT_W = LOG2_MAX_LEN + 1;

   typedef enum logic {S_FILL, S_RUN} state_t;

   state_t                         state, state_next;
   logic signed [DATA_WIDTH-1:0]   ring [DEPTH];
   logic [LOG2_MAX_LEN-1:0]        wr_ptr, rd_idx;
   logic [CNT_W-1:0]               fill_cnt, fill_next, n_val;
   logic [LEN_W-1:0]               len_q, len_clamp;
   logic signed [SUM_W-1:0]        sum, sum_next, din_ext, oldest_ext;
   logic signed [DATA_WIDTH-1:0]   avg;
   logic                           restart, accept, at_full;

   assign len_clamp = (log2_len > LEN_W'(LOG2_MAX_LEN)) ? LEN_W'(LOG2_MAX_LEN) : log2_len;
   assign restart   = clr || (len_clamp != len_q);
   assign accept    = ce && !restart;
   assign n_val     = CNT_W'(1) << len_q;
   // For N = DEPTH the index wraps onto wr_ptr itself: the slot about to be overwritten.
   assign rd_idx    = wr_ptr - n_val[LOG2_MAX_LEN-1:0];
   assign din_ext   = {{LOG2_MAX_LEN{din[DATA_WIDTH-1]}}, din};

   always_comb begin
      oldest_ext = '0;
      if (state == S_RUN) begin
         oldest_ext = {{LOG2_MAX_LEN{ring[rd_idx][DATA_WIDTH-1]}}, ring[rd_idx]};
      end
   end

   assign sum_next = sum + din_ext - oldest_ext;

`ifdef MOVING_AVERAGE_N_ROUND_EN
   logic [SUM_W:0]        bias;
   logic signed [SUM_W:0] rnd_sum;
   assign bias    = ((SUM_W+1)'(1) << len_q) >> 1;
   assign rnd_sum = {sum_next[SUM_W-1], sum_next} + bias;
   assign avg     = DATA_WIDTH'(rnd_sum >>> len_q);
`else
   assign avg     = DATA_WIDTH'(sum_next >>> len_q);
`endif

   always_comb begin
      state_next = state;
      fill_next  = fill_cnt;
      if (restart) begin
         state_next = S_FILL;
      end else if (accept && state == S_FILL) begin
         fill_next = fill_cnt + 1'b1;
         if (fill_next == n_val) begin
            state_next = S_RUN;
         end
      end
   end

   assign at_full = (fill_next == n_val);

   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
         state      <= S_FILL;
         sum        <= '0;
         wr_ptr     <= '0;
         fill_cnt   <= '0;
         len_q      <= '0;
         dout       <= '0;
         dout_valid <= 1'b0;
         filled     <= 1'b0;
      end else begin
         state <= state_next;
         if (restart) begin
            sum        <= '0;
            fill_cnt   <= '0;
            len_q      <= len_clamp;
            dout_valid <= 1'b0;
            filled     <= 1'b0;
         end else if (accept) begin
            sum        <= sum_next;
            fill_cnt   <= fill_next;
            wr_ptr     <= wr_ptr + 1'b1;
            dout       <= avg;
            dout_valid <= at_full;
            filled     <= at_full;
         end else begin
            dout_valid <= 1'b0;
         end
      end
   end

   // Sample storage carries no reset; stale slots are never read while filling.
   always_ff @(posedge clk) begin
      if (accept) begin
         ring[wr_ptr] <= din;
      end
   end

endmodule

// File: tb/tb_moving_average_n.sv
// Self-checking bench for moving_average_n: behavioural window model feeding a scoreboard,
// plus directed checks of the documented scenarios.
module tb_moving_average_n;

   typedef struct {
      logic signed [15:0] dout;
      logic               valid;
   } exp_t;

   logic               clk = 1'b0;
   logic               aresetn;
   logic               ce;
   logic               clr;
   logic [2:0]         log2_len;
   logic signed [15:0] din;
   logic signed [15:0] dout;
   logic               dout_valid;
   logic               filled;

   int                 total = 0;
   int                 bad   = 0;

   exp_t               sb[$];
   int                 hist[$];
   int                 m_len_q;
   logic signed [15:0] m_dout;
   logic               m_filled;
   exp_t               mon_e;

   moving_average_n #(.DATA_WIDTH(16), .LOG2_MAX_LEN(5), .LEN_W(3)) dut (
      .clk(clk), .aresetn(aresetn), .ce(ce), .clr(clr), .log2_len(log2_len),
      .din(din), .dout(dout), .dout_valid(dout_valid), .filled(filled)
   );

   always #5 clk = ~clk;

   function automatic int model_avg(input int s, input int n);
      int t;
      int q;
`ifdef MOVING_AVERAGE_N_ROUND_EN
      t = s + n / 2;
`else
      t = s;
`endif
      q = t / n;
      if ((t % n) != 0 && t < 0) q = q - 1;
      return q;
   endfunction

   task automatic model_reset();
      m_len_q  = 0;
      m_dout   = '0;
      m_filled = 1'b0;
      hist.delete();
      sb.delete();
   endtask

   // One clock cycle of stimulus; the model predicts the post-edge outputs.
   task automatic drive(input logic c, input logic signed [15:0] d, input logic cl,
                        input logic [2:0] l);
      int   clamp;
      int   n;
      int   s;
      exp_t e;
      @(negedge clk);
      ce = c; din = d; clr = cl; log2_len = l;
      clamp = (l > 3'd5) ? 5 : int'(l);
      if (cl || clamp != m_len_q) begin
         m_len_q  = clamp;
         m_filled = 1'b0;
         hist.delete();
      end else if (c) begin
         n = 1 << m_len_q;
         hist.push_back(int'(d));
         if (hist.size() > n) void'(hist.pop_front());
         s = 0;
         foreach (hist[i]) s += hist[i];
         m_dout   = 16'(model_avg(s, n));
         m_filled = (hist.size() == n);
         e.dout   = m_dout;
         e.valid  = m_filled;
         sb.push_back(e);
      end
      @(posedge clk);
      #2;
   endtask

   always @(posedge clk) begin
      #1;
      if (aresetn) begin
         if (sb.size() > 0) begin
            mon_e = sb.pop_front();
            total++;
            if (dout !== mon_e.dout || dout_valid !== mon_e.valid) begin
               bad++;
               $display("FAIL sb_out: dout=%0d valid=%b expected dout=%0d valid=%b",
                        dout, dout_valid, mon_e.dout, mon_e.valid);
            end
         end else begin
            total++;
            if (dout_valid !== 1'b0 || dout !== m_dout) begin
               bad++;
               $display("FAIL idle_out: dout=%0d valid=%b expected dout=%0d valid=0",
                        dout, dout_valid, m_dout);
            end
         end
         total++;
         if (filled !== m_filled) begin
            bad++;
            $display("FAIL filled_track: filled=%b expected %b", filled, m_filled);
         end
      end
   end

   task automatic test_reset();
      aresetn = 1'b0; ce = 1'b0; clr = 1'b0; log2_len = 3'd2; din = '0;
      model_reset();
      repeat (2) @(posedge clk);
      #2;
      total++;
      if (dout !== 16'sd0) begin bad++; $display("FAIL reset_dout: got %0d want 0", dout); end
      total++;
      if (dout_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", dout_valid); end
      total++;
      if (filled !== 1'b0) begin bad++; $display("FAIL reset_filled: got %b want 0", filled); end
      aresetn = 1'b1;
   endtask

   task automatic test_fill_and_decay();
      logic signed [15:0] decay [4];
`ifdef MOVING_AVERAGE_N_ROUND_EN
      decay = '{16'sd11, 16'sd8, 16'sd4, 16'sd0};
`else
      decay = '{16'sd11, 16'sd7, 16'sd3, 16'sd0};
`endif
      drive(1'b0, 16'sd0, 1'b0, 3'd2);
      for (int k = 0; k < 6; k++) begin
         drive(1'b1, 16'sd15, 1'b0, 3'd2);
         total++;
         if (dout_valid !== (k >= 3)) begin
            bad++; $display("FAIL fill_valid[%0d]: got %b want %b", k, dout_valid, k >= 3);
         end
         if (k >= 3) begin
            total++;
            if (dout !== 16'sd15 || filled !== 1'b1) begin
               bad++; $display("FAIL fill_dout[%0d]: dout=%0d filled=%b want 15/1", k, dout, filled);
            end
         end
         repeat (99) drive(1'b0, 16'sd0, 1'b0, 3'd2);
      end
      for (int k = 0; k < 4; k++) begin
         drive(1'b1, 16'sd0, 1'b0, 3'd2);
         total++;
         if (dout !== decay[k] || dout_valid !== 1'b1) begin
            bad++; $display("FAIL decay[%0d]: dout=%0d valid=%b want %0d/1", k, dout, dout_valid, decay[k]);
         end
         repeat (99) drive(1'b0, 16'sd0, 1'b0, 3'd2);
      end
   endtask

   task automatic test_signed_seq();
      logic signed [15:0] seq [5];
      logic signed [15:0] want4, want5;
      seq = '{16'sd10, 16'sd15, 16'sd0, -16'sd15, -16'sd10};
`ifdef MOVING_AVERAGE_N_ROUND_EN
      want4 = 16'sd3;  want5 = -16'sd2;
`else
      want4 = 16'sd2;  want5 = -16'sd3;
`endif
      drive(1'b0, 16'sd0, 1'b1, 3'd2);
      for (int k = 0; k < 5; k++) begin
         drive(1'b1, seq[k], 1'b0, 3'd2);
         drive(1'b0, 16'sd0, 1'b0, 3'd2);
         if (k == 3) begin
            total++;
            if (dout !== want4 || filled !== 1'b1) begin
               bad++; $display("FAIL signed_4th: dout=%0d filled=%b want %0d/1", dout, filled, want4);
            end
         end
         if (k == 4) begin
            total++;
            if (dout !== want5) begin
               bad++; $display("FAIL signed_5th: dout=%0d want %0d", dout, want5);
            end
         end
      end
   endtask

   task automatic test_len_change();
      drive(1'b0, 16'sd0, 1'b0, 3'd5);
      for (int k = 0; k < 32; k++) begin
         drive(1'b1, -16'sd15, 1'b0, 3'd5);
         total++;
         if (dout_valid !== (k == 31)) begin
            bad++; $display("FAIL len32_valid[%0d]: got %b want %b", k, dout_valid, k == 31);
         end
         if (k == 31) begin
            total++;
            if (dout !== -16'sd15) begin bad++; $display("FAIL len32_dout: got %0d want -15", dout); end
         end
         drive(1'b0, 16'sd0, 1'b0, 3'd5);
      end
      drive(1'b0, 16'sd0, 1'b0, 3'd3);
      total++;
      if (filled !== 1'b0) begin bad++; $display("FAIL len_change_filled: got %b want 0", filled); end
      for (int k = 0; k < 8; k++) begin
         drive(1'b1, -16'sd15, 1'b0, 3'd3);
         total++;
         if (dout_valid !== (k == 7)) begin
            bad++; $display("FAIL len8_valid[%0d]: got %b want %b", k, dout_valid, k == 7);
         end
      end
      total++;
      if (dout !== -16'sd15) begin bad++; $display("FAIL len8_dout: got %0d want -15", dout); end
   endtask

   task automatic test_clr_collision();
      drive(1'b1, 16'sd100, 1'b1, 3'd0);
      total++;
      if (dout_valid !== 1'b0 || filled !== 1'b0) begin
         bad++; $display("FAIL clr_collide: valid=%b filled=%b want 0/0", dout_valid, filled);
      end
      drive(1'b1, 16'sd7, 1'b0, 3'd0);
      total++;
      if (dout !== 16'sd7 || dout_valid !== 1'b1 || filled !== 1'b1) begin
         bad++; $display("FAIL n1_first: dout=%0d valid=%b filled=%b want 7/1/1", dout, dout_valid, filled);
      end
      for (int k = 0; k < 4; k++) drive(1'b1, 16'(k * 300 - 500), 1'b0, 3'd0);
   endtask

   task automatic test_back_to_back_reset();
      int r;
      #1;
      aresetn = 1'b0;
      ce = 1'b1; log2_len = 3'd7; clr = 1'b0;
      model_reset();
      #1;
      total++;
      if (dout !== 16'sd0 || dout_valid !== 1'b0 || filled !== 1'b0) begin
         bad++; $display("FAIL async_reset: dout=%0d valid=%b filled=%b want 0/0/0", dout, dout_valid, filled);
      end
      repeat (2) @(posedge clk);
      #2;
      aresetn = 1'b1;
      drive(1'b0, 16'sd0, 1'b0, 3'd7);
      for (int k = 0; k < 40; k++) begin
         r = int'($urandom_range(60000)) - 30000;
         drive(1'b1, 16'(r), 1'b0, 3'd7);
         total++;
         if (dout_valid !== (k >= 31)) begin
            bad++; $display("FAIL b2b_valid[%0d]: got %b want %b", k, dout_valid, k >= 31);
         end
      end
      drive(1'b0, 16'sd0, 1'b0, 3'd7);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL timeout: simulation did not finish within time budget");
      $fatal(1, "timeout");
   end

   initial begin
      test_reset();
      test_fill_and_decay();
      test_signed_seq();
      test_len_change();
      test_clr_collision();
      test_back_to_back_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
